clkdiv_sched: RTL
=================

Name: clkdiv_sched

Overview:
- Programmable tick scheduler and controller for the team's counter-based clock divider datapath.
- Accepts a divide ratio and burst length through a valid/ready config handshake.
- Sequences start, run, abort and completion, and emits single-cycle clock-enable strobes (`tick`) to downstream logic such as shift registers and samplers.
- Sits between the control FSM and the blocks that consume the divided rate.

Parameters:
- CNT_W, 8, width of divide-ratio register and internal period counter
- BURST_W, 8, width of burst-length register and remaining-tick counter

Ports:
- clk  in  1  system clock; all logic on posedge
- n_rst  in  1  reset; one clock; reset is synchronous and active-high (sampled on posedge clk; 1 = reset)
- cfg_valid  in  1  config offered
- cfg_ready  out  1  config can be accepted
- cfg_div  in  CNT_W  period minus one (tick period = cfg_div+1 cycles)
- cfg_burst  in  BURST_W  ticks per run; 0 = continuous
- start  in  1  begin run (level, sampled)
- abort  in  1  terminate run
- tick  out  1  one-cycle enable strobe
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on burst completion
- ticks_left  out  BURST_W  remaining ticks in the current burst

Behaviour:
- States: IDLE, LOADED, RUN, DONE. Internal registers: div_reg, burst_reg, cnt (CNT_W), rem (BURST_W).
- Reset (n_rst=1 at posedge): state=IDLE; all registers 0.
  - Outputs during reset: tick=0, busy=0, done=0, ticks_left=0, cfg_ready=1.
  - Reset mid-RUN aborts immediately; no done pulse.
- cfg_ready=1 in IDLE and LOADED; 0 in RUN and DONE.
- Config handshake: on cfg_valid&&cfg_ready, latch div_reg and burst_reg, then go to LOADED.
- Config takes priority over start in the same cycle: start is ignored that cycle.
- IDLE: start ignored.
- LOADED: start (with no cfg handshake) → RUN next cycle; cnt←0, rem←burst_reg.
- RUN:
  - cnt increments each cycle.
  - When cnt==div_reg: cnt←0 and tick=1 combinationally from registered state (tick = RUN && cnt==div_reg && !abort).
  - Latency: the first tick occurs div_reg+1 cycles after the start-sampling edge. Subsequent ticks every div_reg+1 cycles. div_reg=0 gives tick every cycle.
  - Burst mode (burst_reg≠0): rem decrements on each tick. A tick with rem==1 → DONE next cycle; rem=0.
  - Continuous mode (burst_reg==0): rem stays 0 and ticks run until abort.
  - abort: suppresses tick that cycle → LOADED next cycle. cnt and rem are cleared; div_reg and burst_reg are retained; no done pulse.
  - cnt must not exceed div_reg. CNT_W wrap at div_reg = 2^CNT_W−1 is legal.
- DONE: lasts exactly one cycle with done=1, tick=0 → LOADED. Config is retained, so a new start reruns with no reconfig.
- start held high continuously: in LOADED after DONE it launches a new run, giving one dead cycle (DONE) between bursts.
- busy = (state==RUN). ticks_left = rem.
- start or abort asserted outside their valid states: ignored, no side effects.

Optional Feature:
- Macro: CLKDIV_SCHED_PHASE_EN.
- Defined: adds output phase_out (1 bit), a 50%-style square wave.
  - Reset 0; cleared to 0 on RUN entry.
  - Toggles on every cycle where tick=1.
  - Holds its value in LOADED, DONE and IDLE.
- Undefined: phase_out port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle → tick=0, busy=0, done=0, cfg_ready=1, ticks_left=0; start in IDLE keeps state IDLE.
- cfg_div=3, cfg_burst=4, start → ticks at cycles 4, 8, 12, 16 after the start edge; ticks_left 4→3→2→1→0; done pulses at cycle 17; busy low at cycle 17.
- cfg_div=0, cfg_burst=0, start, abort after 10 cycles → tick every RUN cycle, no tick in the abort cycle, state LOADED, done never asserts.
- cfg_valid and start in the same LOADED cycle with cfg_div=5 → config accepted, no RUN; next start yields first tick 6 cycles later.
- Reset asserted mid-RUN (cfg_div=2, cfg_burst=8, after 2 ticks) → next cycle all outputs at reset values, cfg_ready=1, no done.
- With CLKDIV_SCHED_PHASE_EN: cfg_div=1, cfg_burst=4 → phase_out 0→1→0→1→0 toggling at ticks on cycles 2, 4, 6, 8; ends at 0 and holds.

Source files
------------

// File: rtl/clkdiv_sched.sv
// -----------------------------------------------------------------------------
// clkdiv_sched
// Tick scheduler and controller for the counter-based clock divider. A divide
// ratio and burst length are loaded through a valid/ready handshake. A run is
// then started, aborted or left to complete. While running, the block emits a
// single-cycle clock-enable strobe every (div+1) cycles.
//
// Ports:
//   clk         system clock, all logic on posedge
//   n_rst       synchronous active-high reset (1 = reset)
//   cfg_valid   config offered
//   cfg_ready   config can be accepted (IDLE / LOADED)
//   cfg_div     tick period minus one
//   cfg_burst   ticks per run, 0 = continuous
//   start       begin run (level, sampled in LOADED)
//   abort       terminate run (RUN only)
//   tick        one-cycle enable strobe
//   busy        high while running
//   done        one-cycle pulse on burst completion
//   ticks_left  remaining ticks in the current burst
//   phase_out   square wave toggling on every tick (only with the macro)
//
// Optional feature macro: CLKDIV_SCHED_PHASE_EN adds the phase_out output.
// -----------------------------------------------------------------------------
module clkdiv_sched #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               abort,
  output logic               tick,
  output logic               busy,
  output logic               done,
`ifdef CLKDIV_SCHED_PHASE_EN
  output logic               phase_out,
`endif
  output logic [BURST_W-1:0] ticks_left
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOADED = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_ZERO = {BURST_W{1'b0}};
  localparam logic [BURST_W-1:0] BURST_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] rem_q, rem_d;
`ifdef CLKDIV_SCHED_PHASE_EN
  logic               phase_q, phase_d;
`endif

  logic cfg_ready_s;
  logic cfg_hs_s;
  logic tick_s;

  // Next-state, counter and strobe logic.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
`ifdef CLKDIV_SCHED_PHASE_EN
    phase_d = phase_q;
`endif
    tick_s      = 1'b0;
    cfg_ready_s = (state_q == S_IDLE) || (state_q == S_LOADED);
    cfg_hs_s    = cfg_valid && cfg_ready_s;

    case (state_q)
      S_IDLE: begin
        if (cfg_hs_s) begin
          div_d   = cfg_div;
          burst_d = cfg_burst;
          state_d = S_LOADED;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOADED: begin
        // A config handshake wins over start in the same cycle.
        if (cfg_hs_s) begin
          div_d   = cfg_div;
          burst_d = cfg_burst;
          state_d = S_LOADED;
        end else if (start) begin
          cnt_d   = CNT_ZERO;
          rem_d   = burst_q;
          state_d = S_RUN;
`ifdef CLKDIV_SCHED_PHASE_EN
          phase_d = 1'b0;
`endif
        end else begin
          state_d = S_LOADED;
        end
      end

      S_RUN: begin
        if (abort) begin
          // Abort suppresses any tick due this cycle and keeps the config.
          cnt_d   = CNT_ZERO;
          rem_d   = BURST_ZERO;
          state_d = S_LOADED;
        end else if (cnt_q == div_q) begin
          tick_s = 1'b1;
          cnt_d  = CNT_ZERO;
`ifdef CLKDIV_SCHED_PHASE_EN
          phase_d = ~phase_q;
`endif
          // burst_q == 0 is continuous mode: rem stays 0, no completion.
          if (burst_q != BURST_ZERO) begin
            if (rem_q == BURST_ONE) begin
              rem_d   = BURST_ZERO;
              state_d = S_DONE;
            end else begin
              rem_d = rem_q - BURST_ONE;
            end
          end else begin
            rem_d = BURST_ZERO;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DONE: begin
        state_d = S_LOADED;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= S_IDLE;
      div_q   <= CNT_ZERO;
      burst_q <= BURST_ZERO;
      cnt_q   <= CNT_ZERO;
      rem_q   <= BURST_ZERO;
`ifdef CLKDIV_SCHED_PHASE_EN
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
`ifdef CLKDIV_SCHED_PHASE_EN
      phase_q <= phase_d;
`endif
    end
  end

  // Outputs are forced to their reset values while reset is asserted, so a
  // reset landing mid-run never lets a stale tick or done escape.
  always_comb begin
    if (n_rst) begin
      cfg_ready  = 1'b1;
      tick       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      ticks_left = BURST_ZERO;
`ifdef CLKDIV_SCHED_PHASE_EN
      phase_out  = 1'b0;
`endif
    end else begin
      cfg_ready  = cfg_ready_s;
      tick       = tick_s;
      busy       = (state_q == S_RUN);
      done       = (state_q == S_DONE);
      ticks_left = rem_q;
`ifdef CLKDIV_SCHED_PHASE_EN
      phase_out  = phase_q;
`endif
    end
  end

endmodule
